// File: rtl/reg_to_axi_mst.sv
// Register-bus to AXI4 initiator bridge.
// Each captured register-bus request becomes one single-beat AXI4 transaction
// on a 64-bit port; only one transaction is in flight at a time.
module reg_to_axi_mst #(
    parameter int unsigned AddrWidth    = 48,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned RegDataWidth = AxiDataWidth / 2,
    parameter int unsigned AxiIdWidth   = 2,
    parameter int unsigned AxiId        = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AddrWidth-1:0]      reg_addr_i,
    input  logic                      reg_write_i,
    input  logic [RegDataWidth-1:0]   reg_wdata_i,
    input  logic [RegDataWidth/8-1:0] reg_wstrb_i,
    input  logic                      reg_valid_i,
    output logic                      reg_ready_o,
    output logic [RegDataWidth-1:0]   reg_rdata_o,
    output logic                      reg_error_o,
    output logic [AxiIdWidth-1:0]     aw_id_o,
    output logic [AddrWidth-1:0]      aw_addr_o,
    output logic [2:0]                aw_size_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [AxiDataWidth-1:0]   w_data_o,
    output logic [AxiDataWidth/8-1:0] w_strb_o,
    output logic                      w_last_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    input  logic [1:0]                b_resp_i,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    output logic [AxiIdWidth-1:0]     ar_id_o,
    output logic [AddrWidth-1:0]      ar_addr_o,
    output logic [2:0]                ar_size_o,
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    input  logic [AxiDataWidth-1:0]   r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i,
    input  logic                      r_valid_i,
    output logic                      r_ready_o
);

    localparam int unsigned RegStrbWidth = RegDataWidth / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RSP,
        RD_REQ,
        RD_RSP,
        DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [AddrWidth-1:0]      addr_q, addr_d;
    logic [RegDataWidth-1:0]   wdata_q, wdata_d;
    logic [RegStrbWidth-1:0]   wstrb_q, wstrb_d;
    logic                      aw_pend_q, aw_pend_d;
    logic                      w_pend_q, w_pend_d;
    logic [RegDataWidth-1:0]   rdata_q, rdata_d;
    logic                      error_q, error_d;

    // Low response bits only distinguish OKAY/EXOKAY and SLVERR/DECERR; r_last is implied by len 0.
    logic unused_inputs;
    assign unused_inputs = ^{r_last_i, b_resp_i[0], r_resp_i[0]};

    // Next-state logic: capture the request, then walk the AXI handshakes.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        unique case (state_q)
            IDLE: begin
                if (reg_valid_i) begin
                    addr_d    = reg_addr_i;
                    wdata_d   = reg_wdata_i;
                    wstrb_d   = reg_wstrb_i;
                    aw_pend_d = reg_write_i;
                    w_pend_d  = reg_write_i;
                    state_d   = reg_write_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave once neither is pending.
                if (aw_ready_i) aw_pend_d = 1'b0;
                if (w_ready_i)  w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) state_d = WR_RSP;
            end
            WR_RSP: begin
                if (b_valid_i) begin
                    error_d = b_resp_i[1];
                    state_d = DONE;
                end
            end
            RD_REQ: begin
                if (ar_ready_i) state_d = RD_RSP;
            end
            RD_RSP: begin
                if (r_valid_i) begin
                    rdata_d = addr_q[2] ? r_data_i[RegDataWidth +: RegDataWidth]
                                        : r_data_i[0 +: RegDataWidth];
                    error_d = r_resp_i[1];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    assign reg_ready_o = (state_q == DONE);
    assign reg_rdata_o = rdata_q;
    assign reg_error_o = error_q;

    assign aw_id_o    = AxiIdWidth'(AxiId);
    assign aw_addr_o  = addr_q;
    assign aw_size_o  = 3'd2;
    assign aw_valid_o = (state_q == WR_REQ) && aw_pend_q;

    assign w_data_o   = {wdata_q, wdata_q};
    assign w_strb_o   = addr_q[2] ? {wstrb_q, {RegStrbWidth{1'b0}}}
                                  : {{RegStrbWidth{1'b0}}, wstrb_q};
    assign w_last_o   = 1'b1;
    assign w_valid_o  = (state_q == WR_REQ) && w_pend_q;

    assign b_ready_o  = (state_q == WR_RSP);

    assign ar_id_o    = AxiIdWidth'(AxiId);
    assign ar_addr_o  = addr_q;
    assign ar_size_o  = 3'd2;
    assign ar_valid_o = (state_q == RD_REQ);

    assign r_ready_o  = (state_q == RD_RSP);

endmodule

// File: tb/tb_reg_to_axi_mst.sv
// Scoreboard bench for reg_to_axi_mst: a register-bus master pushes expected
// AXI beats and completions; an AXI slave/monitor process pops and compares.
module tb_reg_to_axi_mst;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [47:0] reg_addr_i;
    logic        reg_write_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  reg_wstrb_i;
    logic        reg_valid_i;
    logic        reg_ready_o;
    logic [31:0] reg_rdata_o;
    logic        reg_error_o;
    logic [1:0]  aw_id_o;
    logic [47:0] aw_addr_o;
    logic [2:0]  aw_size_o;
    logic        aw_valid_o;
    logic        aw_ready_i;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        w_last_o;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [1:0]  b_resp_i;
    logic        b_valid_i;
    logic        b_ready_o;
    logic [1:0]  ar_id_o;
    logic [47:0] ar_addr_o;
    logic [2:0]  ar_size_o;
    logic        ar_valid_o;
    logic        ar_ready_i;
    logic [63:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic        r_last_i;
    logic        r_valid_i;
    logic        r_ready_o;

    always #5 clk = ~clk;

    reg_to_axi_mst #(
        .AddrWidth(48), .AxiDataWidth(64), .RegDataWidth(32), .AxiIdWidth(2), .AxiId(0)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .reg_addr_i(reg_addr_i), .reg_write_i(reg_write_i), .reg_wdata_i(reg_wdata_i),
        .reg_wstrb_i(reg_wstrb_i), .reg_valid_i(reg_valid_i), .reg_ready_o(reg_ready_o),
        .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o),
        .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_size_o(aw_size_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_size_o(ar_size_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
    );

    int nchk = 0;
    int npass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard queues (expected values pushed by the master side).
    logic [47:0] exp_aw_q[$];
    logic [71:0] exp_w_q[$];   // {strb, data}
    logic [47:0] exp_ar_q[$];
    logic [32:0] exp_cpl_q[$]; // {error, rdata}
    logic [65:0] rsp_q[$];     // {resp, rdata64} the slave will return

    // Slave timing knobs, set by the master before each request.
    int aw_lat = 0, w_lat = 0, rsp_lat = 1;
    int aw_hs_count = 0;

    // AXI slave + monitor: all decisions are made at negedge, with outputs
    // stable, for the handshakes that will happen at the following posedge.
    initial begin
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit aw_done, w_done, b_pend, r_pend, aw_drop, w_drop, ar_drop;
        bit prev_rdy, prev_bready;
        logic [65:0] cur;
        logic [71:0] ew;
        logic [32:0] ec;
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
        b_valid_i = 0; b_resp_i = 0; r_valid_i = 0; r_resp_i = 0; r_data_i = 0; r_last_i = 1;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
        aw_drop = 0; w_drop = 0; ar_drop = 0; prev_rdy = 0; prev_bready = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
                aw_drop = 0; w_drop = 0; ar_drop = 0; prev_rdy = 0; prev_bready = 0;
                continue;
            end
            if (aw_drop) check("aw_valid_drop", aw_valid_o, 0);
            if (w_drop)  check("w_valid_drop", w_valid_o, 0);
            if (ar_drop) check("ar_valid_drop", ar_valid_o, 0);
            aw_drop = 0; w_drop = 0; ar_drop = 0;
            if (aw_valid_o || ar_valid_o) check("aw_ar_exclusive", aw_valid_o & ar_valid_o, 0);
            if (reg_ready_o) begin
                check("ready_pulse_width", prev_rdy, 0);
                if (exp_cpl_q.size() == 0) begin
                    nchk++;
                    $display("FAIL unexpected_ready: got ready with empty scoreboard, expected none");
                end else begin
                    ec = exp_cpl_q.pop_front();
                    check("reg_rdata", reg_rdata_o, ec[31:0]);
                    check("reg_error", reg_error_o, ec[32]);
                end
            end
            prev_rdy = reg_ready_o;
            if (b_ready_o && !prev_bready) check("b_ready_after_aw_w", b_pend, 1);
            prev_bready = b_ready_o;

            aw_ready_i = aw_valid_o && !aw_done && (aw_cnt >= aw_lat);
            if (aw_valid_o) aw_cnt++;
            if (aw_valid_o && aw_ready_i) begin
                aw_done = 1; aw_cnt = 0; aw_drop = 1; aw_hs_count++;
                if (exp_aw_q.size() == 0) begin
                    nchk++; $display("FAIL unexpected_aw: got addr 0x%0h, expected no AW", aw_addr_o);
                end else check("aw_addr", aw_addr_o, exp_aw_q.pop_front());
                check("aw_size", aw_size_o, 2);
                check("aw_id", aw_id_o, 0);
            end
            w_ready_i = w_valid_o && !w_done && (w_cnt >= w_lat);
            if (w_valid_o) w_cnt++;
            if (w_valid_o && w_ready_i) begin
                w_done = 1; w_cnt = 0; w_drop = 1;
                if (exp_w_q.size() == 0) begin
                    nchk++; $display("FAIL unexpected_w: got data 0x%0h, expected no W", w_data_o);
                end else begin
                    ew = exp_w_q.pop_front();
                    check("w_data", w_data_o, ew[63:0]);
                    check("w_strb", w_strb_o, ew[71:64]);
                end
                check("w_last", w_last_o, 1);
            end
            if (aw_done && w_done) begin
                aw_done = 0; w_done = 0; b_pend = 1; b_cnt = 0;
                cur = (rsp_q.size() != 0) ? rsp_q.pop_front() : '0;
            end
            ar_ready_i = ar_valid_o && !r_pend && (ar_cnt >= aw_lat);
            if (ar_valid_o) ar_cnt++;
            if (ar_valid_o && ar_ready_i) begin
                ar_cnt = 0; ar_drop = 1; r_pend = 1; r_cnt = 0;
                if (exp_ar_q.size() == 0) begin
                    nchk++; $display("FAIL unexpected_ar: got addr 0x%0h, expected no AR", ar_addr_o);
                end else check("ar_addr", ar_addr_o, exp_ar_q.pop_front());
                check("ar_size", ar_size_o, 2);
                check("ar_id", ar_id_o, 0);
                cur = (rsp_q.size() != 0) ? rsp_q.pop_front() : '0;
            end
            if (b_pend) begin
                b_valid_i = (b_cnt >= rsp_lat); b_resp_i = cur[65:64]; b_cnt++;
                if (b_valid_i && b_ready_o) b_pend = 0;
            end else b_valid_i = 0;
            if (r_pend) begin
                r_valid_i = (r_cnt >= rsp_lat); r_resp_i = cur[65:64]; r_data_i = cur[63:0]; r_cnt++;
                if (r_valid_i && r_ready_o) r_pend = 0;
            end else r_valid_i = 0;
        end
    end

    // Reference state of the register-bus view: last read data returned.
    logic [31:0] last_rdata = '0;

    // Issue one request and wait for its completion; extra=1 when the request
    // is presented during the previous completion cycle (valid held high).
    task automatic issue(input bit wr, input logic [47:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input int al, input int wl, input int rl,
                         input logic [1:0] resp, input logic [63:0] rd, input int extra);
        int h, exp_lat, cyc;
        bit done;
        aw_lat = al; w_lat = wl; rsp_lat = rl;
        reg_write_i = wr; reg_addr_i = a; reg_wdata_i = wd; reg_wstrb_i = ws; reg_valid_i = 1;
        rsp_q.push_back({resp, rd});
        if (wr) begin
            exp_aw_q.push_back(a);
            exp_w_q.push_back({a[2] ? {ws, 4'h0} : {4'h0, ws}, wd, wd});
        end else begin
            exp_ar_q.push_back(a);
            last_rdata = a[2] ? rd[63:32] : rd[31:0];
        end
        exp_cpl_q.push_back({resp[1], last_rdata});
        h = 1 + (wr ? ((al > wl) ? al : wl) : al);
        exp_lat = h + 1 + ((rl > 1) ? rl : 1) + extra;
        cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            @(posedge clk); #2;
            cyc++;
            if (reg_ready_o) done = 1;
        end
        if (!done) begin
            nchk++;
            $display("FAIL completion_timeout: got no ready in 200 cycles, expected ready");
        end else check("ready_latency", cyc, exp_lat);
    endtask

    task automatic go_idle();
        reg_valid_i = 0;
        @(posedge clk); #2;
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_reg_ready"}, reg_ready_o, 0);
        check({tag, "_reg_rdata"}, reg_rdata_o, 0);
        check({tag, "_reg_error"}, reg_error_o, 0);
        check({tag, "_aw_valid"}, aw_valid_o, 0);
        check({tag, "_w_valid"}, w_valid_o, 0);
        check({tag, "_b_ready"}, b_ready_o, 0);
        check({tag, "_ar_valid"}, ar_valid_o, 0);
        check({tag, "_r_ready"}, r_ready_o, 0);
        check({tag, "_addr"}, aw_addr_o, 0);
        check({tag, "_w_strb"}, w_strb_o, 0);
    endtask

    initial begin
        int hs0, n;
        bit held;
        rst_i = 1; reg_valid_i = 0; reg_write_i = 0; reg_addr_i = '0; reg_wdata_i = '0; reg_wstrb_i = '0;
        repeat (3) @(posedge clk);
        #2;
        check_quiet_outputs("reset");
        rst_i = 0;
        @(posedge clk); #2;

        // Basic write to the upper word lane, then reads of both lanes.
        issue(1, 48'h0000_0200_3004, 32'hDEADBEEF, 4'hF, 0, 0, 2, 2'b00, 64'h0, 0);
        go_idle();
        issue(0, 48'h0000_7000_0000, 32'h0, 4'h0, 0, 0, 2, 2'b00, 64'h11223344_55667788, 0);
        go_idle();
        issue(0, 48'h0000_7000_0004, 32'h0, 4'h0, 0, 0, 2, 2'b00, 64'h11223344_55667788, 0);
        go_idle();
        // Independent AW/W handshake timing, both orders.
        issue(1, 48'h0000_1000_0000, 32'h0BADF00D, 4'h3, 3, 0, 1, 2'b00, 64'h0, 0);
        go_idle();
        issue(1, 48'h0000_1000_0004, 32'hCAFEF00D, 4'h9, 0, 3, 1, 2'b01, 64'h0, 0);
        go_idle();
        // Error responses.
        issue(0, 48'h0000_2000_0008, 32'h0, 4'h0, 1, 0, 1, 2'b11, 64'hA5A5A5A5_5A5A5A5A, 0);
        go_idle();
        issue(1, 48'h0000_2000_000C, 32'h12345678, 4'hC, 0, 0, 1, 2'b10, 64'h0, 0);
        go_idle();

        // Reset while a write is stuck in the request phase.
        aw_lat = 20; w_lat = 20;
        reg_write_i = 1; reg_addr_i = 48'h0000_3000_0000; reg_wdata_i = 32'h1; reg_wstrb_i = 4'hF;
        reg_valid_i = 1;
        n = 0;
        while (!aw_valid_o && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("rst_test_aw_valid_seen", aw_valid_o, 1);
        rst_i = 1; reg_valid_i = 0;
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_cpl_q.delete(); rsp_q.delete();
        last_rdata = '0;
        @(posedge clk); #2;
        check_quiet_outputs("midrst");
        rst_i = 0;
        @(posedge clk); #2;
        issue(0, 48'h0000_3000_0004, 32'h0, 4'h0, 0, 0, 2, 2'b00, 64'hFEEDFACE_01020304, 0);
        go_idle();

        // Three writes with valid held high: one transaction each, 5 cycles apart.
        hs0 = aw_hs_count;
        issue(1, 48'h0000_4000_0000, 32'h11111111, 4'hF, 0, 0, 2, 2'b00, 64'h0, 0);
        issue(1, 48'h0000_4000_0004, 32'h22222222, 4'h1, 0, 0, 2, 2'b00, 64'h0, 1);
        issue(1, 48'h0000_4000_0008, 32'h33333333, 4'h8, 0, 0, 2, 2'b00, 64'h0, 1);
        go_idle();
        repeat (3) @(posedge clk);
        #2;
        check("b2b_aw_handshakes", aw_hs_count - hs0, 3);

        // Randomized traffic.
        held = 0;
        for (int i = 0; i < 40; i++) begin
            logic [63:0] a64, d64;
            a64 = {$urandom, $urandom};
            d64 = {$urandom, $urandom};
            issue(1'($urandom_range(0, 1)), a64[47:0], $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  2'($urandom_range(0, 3)), d64, held ? 1 : 0);
            held = ($urandom_range(0, 1) == 1);
            if (!held) go_idle();
        end
        go_idle();
        repeat (5) @(posedge clk);
        #2;
        check("scoreboard_drained",
              exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_cpl_q.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
